elevator_call_scheduler: RTL and testbench

- Upstream stage of the elevator controller. Latches floor call buttons into a pending set and runs a SCAN (sweep) policy to pick the next target floor.
- Drives the controller's 4-bit `req` target.
- Tracks the car position by counting the controller's registered `up`/`dwn` outputs, and retires a call when `complete` is seen at the target.
- Returns the car to a home floor after a programmable idle time.

---
 rtl/elevator_call_scheduler.sv | 169 ++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler in front of the elevator controller: latches floor calls,
// tracks the car from the controller's up/dwn outputs and picks the next target.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS = 16,
  parameter int HOME_FLOOR = 0,
  parameter int IDLE_HOME  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic                  up,
  input  logic                  dwn,
  input  logic                  complete,
  output logic [3:0]            req,
  output logic [3:0]            cur_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic                  door_open,
  output logic [3:0]            served_floor
);

  localparam logic [3:0] TOP_FLOOR  = 4'(NUM_FLOORS - 1);
  localparam logic [3:0] HOME       = 4'(HOME_FLOOR);
  localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_HOME);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DN, S_HOME} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            cur_floor_reg, cur_floor_next;
  logic [3:0]            req_reg, req_next;
  logic [NUM_FLOORS-1:0] pending_reg, pending_next;
  logic                  door_open_reg, door_open_next;
  logic [3:0]            served_floor_reg, served_floor_next;
  logic [7:0]            idle_cnt_reg, idle_cnt_next;

  logic                  stopped, moving_up, moving_dn, serve;
  logic [NUM_FLOORS-1:0] req_hot, reach, cand_up, cand_dn;
  logic                  up_found, dn_found, pick_up, any_cand;
  logic [3:0]            up_idx, dn_idx;

  assign stopped   = !up && !dwn;
  assign moving_up = up && !dwn;
  assign moving_dn = dwn && !up;
  assign serve     = complete && stopped && (cur_floor_reg == req_reg) && |(pending_reg & req_hot);

  // A moving car can only still stop two floors ahead of the tracked position.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      localparam logic [4:0] F = 5'(gi);
      assign req_hot[gi]      = (req_reg == F[3:0]);
      assign pending_next[gi] = (pending_reg[gi] | call_btn[gi]) & ~(serve & req_hot[gi]);
      assign reach[gi]        = stopped
                              || (moving_up && (F >= {1'b0, cur_floor_reg} + 5'd2))
                              || (moving_dn && (F + 5'd2 <= {1'b0, cur_floor_reg}));
      assign cand_up[gi]      = pending_next[gi] & reach[gi] & (F[3:0] >= cur_floor_reg);
      assign cand_dn[gi]      = pending_next[gi] & reach[gi] & (F[3:0] <= cur_floor_reg);
    end
  endgenerate

  always_comb begin
    up_found = 1'b0;
    up_idx   = 4'd0;
    dn_found = 1'b0;
    dn_idx   = 4'd0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (cand_up[i]) begin
        up_found = 1'b1;
        up_idx   = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (cand_dn[i]) begin
        dn_found = 1'b1;
        dn_idx   = 4'(i);
      end
    end
  end

  // Nearest call wins; equal distance (including a call at the car) goes up.
  assign pick_up  = up_found && (!dn_found || ((up_idx - cur_floor_reg) <= (cur_floor_reg - dn_idx)));
  assign any_cand = up_found || dn_found;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= S_IDLE;
      cur_floor_reg    <= 4'd0;
      req_reg          <= 4'd0;
      pending_reg      <= '0;
      door_open_reg    <= 1'b0;
      served_floor_reg <= 4'd0;
      idle_cnt_reg     <= 8'd0;
    end else begin
      state_reg        <= state_next;
      cur_floor_reg    <= cur_floor_next;
      req_reg          <= req_next;
      pending_reg      <= pending_next;
      door_open_reg    <= door_open_next;
      served_floor_reg <= served_floor_next;
      idle_cnt_reg     <= idle_cnt_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    req_next          = req_reg;
    idle_cnt_next     = 8'd0;
    door_open_next    = serve;
    served_floor_next = serve ? req_reg : served_floor_reg;

    if (moving_up && cur_floor_reg != TOP_FLOOR) begin
      cur_floor_next = cur_floor_reg + 4'd1;
    end else if (moving_dn && cur_floor_reg != 4'd0) begin
      cur_floor_next = cur_floor_reg - 4'd1;
    end else begin
      cur_floor_next = cur_floor_reg;
    end

    case (state_reg)
      S_IDLE: begin
        if (any_cand) begin
          state_next = pick_up ? S_UP : S_DN;
          req_next   = pick_up ? up_idx : dn_idx;
        end else if (IDLE_HOME != 0 && idle_cnt_reg == IDLE_LIMIT && cur_floor_reg != HOME) begin
          state_next = S_HOME;
          req_next   = HOME;
        end else if (stopped) begin
          idle_cnt_next = (idle_cnt_reg == 8'hFF) ? idle_cnt_reg : idle_cnt_reg + 8'd1;
        end
      end
      S_HOME: begin
        if (any_cand) begin
          state_next = pick_up ? S_UP : S_DN;
          req_next   = pick_up ? up_idx : dn_idx;
        end else if (complete && stopped && cur_floor_reg == HOME) begin
          state_next = S_IDLE;
        end
      end
      // While travelling, only a nearer reachable call may replace the target.
      S_UP: begin
        if (up_found && (serve || up_idx < req_reg)) begin
          req_next = up_idx;
        end else if (serve) begin
          state_next = dn_found ? S_DN : S_IDLE;
          req_next   = dn_found ? dn_idx : req_reg;
        end
      end
      S_DN: begin
        if (dn_found && (serve || dn_idx > req_reg)) begin
          req_next = dn_idx;
        end else if (serve) begin
          state_next = up_found ? S_UP : S_IDLE;
          req_next   = up_found ? up_idx : req_reg;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req          = req_reg;
    cur_floor    = cur_floor_reg;
    pending      = pending_reg;
    busy         = (state_reg != S_IDLE);
    door_open    = door_open_reg;
    served_floor = served_floor_reg;
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler with a one-floor-per-cycle controller model
// and a queue of expected service order checked on every door_open pulse.
module tb_elevator_call_scheduler;
  localparam int NF = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NF-1:0] call_btn = '0;
  logic          up, dwn, complete;
  logic [3:0]    req, cur_floor, served_floor;
  logic [NF-1:0] pending;
  logic          busy, door_open;
  logic [3:0]    car;

  int n_cmp = 0;
  int n_err = 0;
  int served_cnt = 0;
  int up_cnt = 0;
  int dwn_cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  elevator_call_scheduler dut (
    .clk(clk), .rst(rst), .call_btn(call_btn), .up(up), .dwn(dwn), .complete(complete),
    .req(req), .cur_floor(cur_floor), .pending(pending), .busy(busy),
    .door_open(door_open), .served_floor(served_floor)
  );

  // Controller: one floor per cycle toward req, registered up/dwn/complete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car <= 4'd0; up <= 1'b0; dwn <= 1'b0; complete <= 1'b0;
    end else if (car < req) begin
      car <= car + 4'd1; up <= 1'b1; dwn <= 1'b0; complete <= 1'b0;
    end else if (car > req) begin
      car <= car - 4'd1; up <= 1'b0; dwn <= 1'b1; complete <= 1'b0;
    end else begin
      up <= 1'b0; dwn <= 1'b0; complete <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (up) up_cnt++;
      if (dwn) dwn_cnt++;
      if (door_open) begin
        served_cnt++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL door_unexpected observed=%0d expected=none", served_floor);
        end
        if (exp_q.size() != 0) check("served_floor", served_floor, exp_q.pop_front());
        $display("serve #%0d floor=%0d pending=%h", served_cnt, served_floor, pending);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int f);
    call_btn    = '0;
    call_btn[f] = 1'b1;
    tick();
    call_btn    = '0;
  endtask

  task automatic wait_served(input int n, input int budget, input string tag);
    int k = 0;
    while (served_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, served_cnt, n);
  endtask

  // mv: 0 any, 1 moving up, 2 moving down
  task automatic wait_cur(input logic [3:0] f, input int mv, input int budget, input string tag);
    int k = 0;
    while (!(cur_floor == f && (mv == 0 || (mv == 1 && up) || (mv == 2 && dwn))) && k < budget) begin
      tick();
      k++;
    end
    check(tag, {cur_floor, up, dwn}, {f, (mv == 1), (mv == 2)});
  endtask

  task automatic wait_home(input int budget, input string tag);
    int k = 0;
    while (!(busy && req == 4'd0) && k < budget) begin
      tick();
      k++;
    end
    check(tag, {busy, req}, {1'b1, 4'd0});
  endtask

  task automatic wait_parked(input logic [3:0] f, input int budget, input string tag);
    int k = 0;
    while (!(!busy && cur_floor == f && !up && !dwn) && k < budget) begin
      tick();
      k++;
    end
    check(tag, {busy, cur_floor}, {1'b0, f});
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_req"}, req, 0);
    check({pfx, "_cur"}, cur_floor, 0);
    check({pfx, "_pending"}, pending, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_door"}, door_open, 0);
    check({pfx, "_served"}, served_floor, 0);
  endtask

  initial begin
    #1;
    check_zero("rst");
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Single call from floor 0
    exp_q.push_back(5);
    up_cnt = 0;
    pulse(5);
    check("t1_req", req, 5);
    check("t1_busy", busy, 1);
    wait_served(1, 40, "t1_served");
    check("t1_door", door_open, 1);
    check("t1_idle", busy, 0);
    check("t1_pending", pending, 0);
    check("t1_up_cycles", up_cnt, 5);
    tick();
    check("t1_door_pulse", door_open, 0);
    check("t1_served_hold", served_floor, 5);
    wait_home(40, "t1_home");
    wait_parked(4'd0, 40, "t1_parked");

    // Retarget to a nearer reachable call, refuse an unreachable one
    exp_q.push_back(4); exp_q.push_back(9); exp_q.push_back(3);
    pulse(9);
    wait_cur(4'd1, 1, 20, "t2_at1");
    pulse(4);
    check("t2_retarget", req, 4);
    wait_cur(4'd3, 1, 20, "t2_at3");
    pulse(3);
    check("t2_no_retarget", req, 4);
    wait_served(4, 200, "t2_served");

    // Sweep up then down
    exp_q.push_back(12); exp_q.push_back(5); exp_q.push_back(2);
    pulse(12);
    wait_cur(4'd8, 1, 30, "t3_at8");
    call_btn = 16'h0024;
    tick();
    call_btn = '0;
    check("t3_hold_target", req, 12);
    wait_served(5, 60, "t3_served12");
    check("t3_pending", pending, 16'h0024);
    tick();
    check("t3_dwn_after_12", dwn, 1);
    wait_served(7, 100, "t3_served_rest");

    // Call at the car's floor, then a held button
    exp_q.push_back(2);
    up_cnt = 0;
    dwn_cnt = 0;
    pulse(2);
    wait_served(8, 2, "t4_inplace");
    check("t4_no_motion", up_cnt + dwn_cnt, 0);
    exp_q.push_back(2); exp_q.push_back(2);
    call_btn[2] = 1'b1;
    wait_served(9, 4, "t4_hold_first");
    check("t4_cleared", pending[2], 0);
    tick();
    check("t4_reset_bit", pending[2], 1);
    call_btn = '0;
    wait_served(10, 4, "t4_hold_second");
    check("t4_pending_empty", pending, 0);

    // Homing and abort by a new call
    exp_q.push_back(6);
    pulse(6);
    wait_served(11, 30, "t5_served6");
    wait_home(40, "t5_home");
    wait_cur(4'd5, 2, 20, "t5_at5");
    exp_q.push_back(3);
    pulse(3);
    check("t5_abort", {busy, req}, {1'b1, 4'd3});
    wait_served(12, 30, "t5_served3");

    // Reset mid-trip discards everything
    pulse(9);
    wait_cur(4'd7, 1, 30, "t6_at7");
    rst = 1'b0;
    #1;
    check_zero("t6_rst");
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    exp_q.push_back(2);
    up_cnt = 0;
    pulse(2);
    wait_served(13, 30, "t6_served2");
    check("t6_up_from0", up_cnt, 2);
    check("t6_cur", cur_floor, 2);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
